cnn_layer_accel_ce_macc_ctrl: RTL and testbench

- Issue-side sequencer and result collector for one CE MACC slice (a DSP48E2 with AREG=BREG=2, MREG=1, PREG=1, OPMODEREG=ALUMODEREG=1, CREG=0).
- Accepts a stream of (pixel, weight) pairs and drives A, B, opmode, alumode, CE and rst of the MACC.
- Groups every cfg_len consecutive products into one dot product, captures the finished P into a small result FIFO, and presents it downstream with valid/ready.

---
 rtl/cnn_layer_accel_macc_pkg.sv | 28 ++
 rtl/cnn_layer_accel_ce_macc_ctrl_if.sv | 24 ++
 rtl/cnn_layer_accel_result_fifo.sv | 52 +++++
 rtl/cnn_layer_accel_ce_macc_ctrl.sv | 123 ++++++++++++
 tb/tb_cnn_layer_accel_ce_macc_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_layer_accel_macc_pkg.sv
// rtl/cnn_layer_accel_macc_pkg.sv - MACC control constants, slot type and opmode decode
package cnn_layer_accel_macc_pkg;

  localparam logic [8:0] OPMODE_MULT = 9'b000000101;
  localparam logic [8:0] OPMODE_MACC = 9'b000100101;
  localparam logic [8:0] OPMODE_HOLD = 9'b000100000;
  localparam logic [3:0] ALUMODE_SUM = 4'b0000;

  localparam int MACC_LAT    = 4;
  localparam int OPMODE_SKEW = 2;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } slot_t;

  // Bubbles hold P so a window survives input gaps.
  function automatic logic [8:0] slot_opmode(slot_t s);
    if (!s.valid)
      return OPMODE_HOLD;
    else if (s.first)
      return OPMODE_MULT;
    else
      return OPMODE_MACC;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_ce_macc_ctrl_if.sv
// rtl/cnn_layer_accel_ce_macc_ctrl_if.sv - pair input stream and result output stream
interface cnn_layer_accel_ce_macc_ctrl_if #(
  parameter int C_A_INPUT_WIDTH  = 30,
  parameter int C_B_INPUT_WIDTH  = 18,
  parameter int C_P_OUTPUT_WIDTH = 48
) ();
  logic                        in_valid;
  logic                        in_ready;
  logic [C_A_INPUT_WIDTH-1:0]  in_a;
  logic [C_B_INPUT_WIDTH-1:0]  in_b;
  logic                        out_valid;
  logic                        out_ready;
  logic [C_P_OUTPUT_WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cnn_layer_accel_result_fifo.sv
// rtl/cnn_layer_accel_result_fifo.sv - first-word-fall-through result FIFO with occupancy count
module cnn_layer_accel_result_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cnn_layer_accel_ce_macc_ctrl.sv
// rtl/cnn_layer_accel_ce_macc_ctrl.sv - issue sequencer and result collector for one CE MACC slice
module cnn_layer_accel_ce_macc_ctrl
  import cnn_layer_accel_macc_pkg::*;
#(
  parameter int C_A_INPUT_WIDTH  = 30,
  parameter int C_B_INPUT_WIDTH  = 18,
  parameter int C_P_OUTPUT_WIDTH = 48,
  parameter int LEN_WIDTH        = 10,
  parameter int OUT_DEPTH        = 4
) (
  input  logic                        CLK,
  input  logic                        rst_n,
  input  logic [LEN_WIDTH-1:0]        cfg_len,
  cnn_layer_accel_ce_macc_ctrl_if.slave io,
  output logic                        macc_rst,
  output logic                        macc_ce,
  output logic [8:0]                  macc_opmode,
  output logic [3:0]                  macc_alumode,
  output logic [C_A_INPUT_WIDTH-1:0]  macc_a,
  output logic [C_B_INPUT_WIDTH-1:0]  macc_b,
  input  logic [C_P_OUTPUT_WIDTH-1:0] macc_p,
  output logic                        busy
);
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  logic [1:0]                  rst_sh;
  logic                        ce_q;
  logic [LEN_WIDTH-1:0]        idx;
  logic [LEN_WIDTH-1:0]        len;
  logic [LEN_WIDTH-1:0]        win_len;
  slot_t                       skew [OPMODE_SKEW];
  slot_t                       tag  [MACC_LAT];
  slot_t                       slot_in;
  logic                        accept;
  logic                        pend;
  logic                        hold;
  logic [CW:0]                 occ;
  logic [CW-1:0]               fifo_count;
  logic                        fifo_empty;
  logic                        out_valid_w;
  logic [C_P_OUTPUT_WIDTH-1:0] out_data_w;

  // Capture only on the cycle right after the last tag advanced into stage 4, so a stall cannot re-capture it.
  assign pend = ce_q && tag[MACC_LAT-1].valid && tag[MACC_LAT-1].last;
  assign occ  = {1'b0, fifo_count} + (CW+1)'(pend);
  assign hold = (occ >= (CW+1)'(OUT_DEPTH));

  assign macc_rst     = rst_sh[1];
  assign macc_ce      = !rst_sh[1] && !hold;
  assign macc_alumode = ALUMODE_SUM;
  assign accept       = macc_ce && io.in_valid;
  assign io.in_ready  = macc_ce;
  assign io.out_valid = out_valid_w;
  assign io.out_data  = out_data_w;
  assign out_valid_w  = !fifo_empty;

  always_comb begin
    win_len = len;
    if (idx == '0)
      win_len = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    slot_in.valid = accept;
    slot_in.first = accept && (idx == '0);
    slot_in.last  = accept && (idx == win_len - 1'b1);
  end

  always_comb begin
    busy = (idx != '0) || !fifo_empty;
    for (int i = 0; i < OPMODE_SKEW; i++)
      busy = busy || skew[i].valid;
    for (int i = 0; i < MACC_LAT; i++)
      busy = busy || tag[i].valid;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rst_sh      <= 2'b11;
      ce_q        <= 1'b0;
      idx         <= '0;
      len         <= '0;
      macc_a      <= '0;
      macc_b      <= '0;
      macc_opmode <= '0;
      for (int i = 0; i < OPMODE_SKEW; i++)
        skew[i] <= '0;
      for (int i = 0; i < MACC_LAT; i++)
        tag[i] <= '0;
    end else begin
      rst_sh <= {rst_sh[0], 1'b0};
      ce_q   <= macc_ce;
      if (macc_ce) begin
        macc_a  <= accept ? io.in_a : '0;
        macc_b  <= accept ? io.in_b : '0;
        skew[0] <= slot_in;
        for (int i = 1; i < OPMODE_SKEW; i++)
          skew[i] <= skew[i-1];
        // OPMODEREG sits two stages closer to P than AREG/BREG, hence the skew.
        macc_opmode <= slot_opmode(skew[OPMODE_SKEW-1]);
        tag[0] <= skew[0];
        for (int i = 1; i < MACC_LAT; i++)
          tag[i] <= tag[i-1];
        if (accept) begin
          if (idx == '0)
            len <= win_len;
          idx <= slot_in.last ? '0 : idx + 1'b1;
        end
      end
    end
  end

  cnn_layer_accel_result_fifo #(
    .W     (C_P_OUTPUT_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_result_fifo (
    .clk       (CLK),
    .rst_n     (rst_n),
    .push      (pend),
    .push_data (macc_p),
    .pop       (out_valid_w && io.out_ready),
    .head      (out_data_w),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_cnn_layer_accel_ce_macc_ctrl.sv
// tb/tb_cnn_layer_accel_ce_macc_ctrl.sv - scoreboard bench with a behavioural DSP48E2 slice model
module tb_cnn_layer_accel_ce_macc_ctrl;
  localparam int AW = 30;
  localparam int BW = 18;
  localparam int PW = 48;
  localparam int LW = 10;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          macc_rst;
  logic          macc_ce;
  logic [8:0]    macc_opmode;
  logic [3:0]    macc_alumode;
  logic [AW-1:0] macc_a;
  logic [BW-1:0] macc_b;
  logic [PW-1:0] macc_p;
  logic          busy;

  always #5 CLK = ~CLK;

  cnn_layer_accel_ce_macc_ctrl_if #(
    .C_A_INPUT_WIDTH(AW), .C_B_INPUT_WIDTH(BW), .C_P_OUTPUT_WIDTH(PW)
  ) bus ();

  cnn_layer_accel_ce_macc_ctrl #(
    .C_A_INPUT_WIDTH(AW), .C_B_INPUT_WIDTH(BW), .C_P_OUTPUT_WIDTH(PW),
    .LEN_WIDTH(LW), .OUT_DEPTH(4)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .cfg_len      (cfg_len),
    .io           (bus),
    .macc_rst     (macc_rst),
    .macc_ce      (macc_ce),
    .macc_opmode  (macc_opmode),
    .macc_alumode (macc_alumode),
    .macc_a       (macc_a),
    .macc_b       (macc_b),
    .macc_p       (macc_p),
    .busy         (busy)
  );

  // DSP48E2: AREG=BREG=2, MREG=1, PREG=1, OPMODEREG=1, synchronous reset, single CE.
  logic signed [AW-1:0] a1 = '0, a2 = '0;
  logic signed [BW-1:0] b1 = '0, b2 = '0;
  logic signed [PW-1:0] m = '0, p = '0;
  logic [8:0]           opm = '0;
  always @(posedge CLK) begin
    if (macc_rst) begin
      a1 <= '0; a2 <= '0; b1 <= '0; b2 <= '0; m <= '0; p <= '0; opm <= '0;
    end else if (macc_ce) begin
      a1  <= macc_a;
      a2  <= a1;
      b1  <= macc_b;
      b2  <= b1;
      m   <= a2 * b2;
      opm <= macc_opmode;
      p   <= ((opm[6:4] == 3'b010) ? p : '0) + ((opm[3:0] == 4'b0101) ? m : '0);
    end
  end
  assign macc_p = p;

  int                   n_cmp = 0;
  int                   n_fail = 0;
  int                   cyc = 0;
  int                   last_acc = 0;
  logic signed [PW-1:0] exp_q [$];
  int                   out_cyc [$];
  logic [8:0]           op_log [int];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    logic signed [PW-1:0] e;
    op_log[cyc] = macc_opmode;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_extra: got %0d, no result expected", $signed(bus.out_data));
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL result: got %0d, expected %0d", $signed(bus.out_data), e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge CLK);
    while (!bus.in_ready && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) chk("send_timeout", 64'(n), 64'(0));
    step();
    last_acc     = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    step();
  endtask

  initial begin
    int t0, t1, t2, n;
    bus.in_valid  = 1'b1;
    bus.in_a      = 30'sd5;
    bus.in_b      = 18'sd5;
    bus.out_ready = 1'b1;

    // Reset with in_valid held high.
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_macc_rst", 64'(macc_rst), 64'(1));
    chk("rst_macc_ce", 64'(macc_ce), 64'(0));
    chk("rst_opmode", 64'(macc_opmode), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("alumode", 64'(macc_alumode), 64'(0));
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rel1_macc_rst", 64'(macc_rst), 64'(1));
    chk("rel1_macc_ce", 64'(macc_ce), 64'(0));
    @(posedge CLK);
    @(negedge CLK);
    chk("rel2_macc_rst", 64'(macc_rst), 64'(0));
    chk("rel2_macc_ce", 64'(macc_ce), 64'(1));
    chk("rel2_in_ready", 64'(bus.in_ready), 64'(1));
    step();

    // Dot product, back-to-back pairs: 6 - 20 - 7 = -21.
    cfg_len = 3;
    exp_q.push_back(-48'sd21);
    send(2, 3);   t0 = last_acc;
    send(-4, 5);  t1 = last_acc;
    send(7, -1);  t2 = last_acc;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("dot_latency", 64'(bus.out_valid ? cyc - t2 : -1), 64'(5));
    chk("dot_op0", 64'(op_log[t0+2]), 64'h005);
    chk("dot_op1", 64'(op_log[t1+2]), 64'h025);
    chk("dot_op2", 64'(op_log[t2+2]), 64'h025);
    wait_drain();

    // Same window with two idle cycles between pairs.
    exp_q.push_back(-48'sd21);
    send(2, 3);   t0 = last_acc;
    idle(2);
    send(-4, 5);  t1 = last_acc;
    idle(2);
    send(7, -1);  t2 = last_acc;
    wait_drain();
    chk("gap_op0", 64'(op_log[t0+2]), 64'h005);
    chk("gap_bubble", 64'(op_log[t0+3]), 64'h020);
    chk("gap_op1", 64'(op_log[t1+2]), 64'h025);
    chk("gap_op2", 64'(op_log[t2+2]), 64'h025);

    // len=1 windows back-to-back: one result per cycle.
    cfg_len = 1;
    out_cyc.delete();
    for (int k = 1; k <= 8; k++) exp_q.push_back(PW'(k));
    for (int k = 1; k <= 8; k++) send(AW'(k), 1);
    wait_drain();
    chk("b2b_count", 64'(out_cyc.size()), 64'(8));
    if (out_cyc.size() == 8) chk("b2b_span", 64'(out_cyc[7] - out_cyc[0]), 64'(7));

    // Backpressure: FIFO fills, issue stalls, then everything drains in order.
    out_cyc.delete();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) exp_q.push_back(PW'(-2 * (3 * k - 7)));
    fork
      begin
        for (int k = 1; k <= 10; k++) send(AW'(3 * k - 7), -2);
      end
      begin
        repeat (25) @(posedge CLK);
        @(negedge CLK);
        chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
        chk("bp_macc_ce", 64'(macc_ce), 64'(0));
        chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
        chk("bp_busy", 64'(busy), 64'(1));
        step();
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    idle(3);
    chk("bp_count", 64'(out_cyc.size()), 64'(10));

    // cfg_len=0 behaves as a single-product window.
    cfg_len = 0;
    exp_q.push_back(-48'sd27);
    send(9, -3);
    wait_drain();

    // Reset in the middle of a window discards the partial sum.
    cfg_len = 4;
    send(5, 5);
    send(6, 6);
    step();
    rst_n = 1'b0;
    @(negedge CLK);
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    step();
    rst_n = 1'b1;
    exp_q.push_back(48'sd4);
    for (int k = 0; k < 4; k++) send(1, 1);
    wait_drain();
    idle(8);
    chk("end_queue", 64'(exp_q.size()), 64'(0));
    chk("end_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
